// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multicycle LEGv8-style CPU:
// FSM states, instruction classes, ALU op codes and opcode match patterns.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ILLEGAL,
        C_B,
        C_CBZ,
        C_ADDI,
        C_ADDS,
        C_SUBS,
        C_LDUR,
        C_STUR
    } iclass_t;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;

    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    function automatic logic is_rtype(iclass_t c);
        return (c == C_ADDS) || (c == C_SUBS);
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational classification of instruction[31:21] into an instruction
// class; earlier patterns win where the short-prefix formats overlap.
module opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [10:0] i_opcode,
    output iclass_t     o_class
);

    always_comb begin
        o_class = C_ILLEGAL;
        if (i_opcode[10:5] == OP_B)
            o_class = C_B;
        else if (i_opcode[10:3] == OP_CBZ)
            o_class = C_CBZ;
        else if (i_opcode[10:1] == OP_ADDI)
            o_class = C_ADDI;
        else if (i_opcode == OP_ADDS)
            o_class = C_ADDS;
        else if (i_opcode == OP_SUBS)
            o_class = C_SUBS;
        else if (i_opcode == OP_LDUR)
            o_class = C_LDUR;
        else if (i_opcode == OP_STUR)
            o_class = C_STUR;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/
// writeback and counts retired instructions (one per pc_write pulse).
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_is_instr,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        flag_write,
    output logic        reg2loc,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        uncond_br,
    output logic        br_taken,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic [31:0] retired
);

    state_t      r_state;
    state_t      w_next;
    iclass_t     w_class;
    logic [31:0] r_retired;

    opcode_decode u_dec (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (pc_write)
                r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;

    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        mem_is_instr = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        flag_write   = 1'b0;
        reg2loc      = 1'b0;
        alu_src      = 1'b0;
        mem_to_reg   = 1'b0;
        uncond_br    = 1'b0;
        br_taken     = 1'b0;
        alu_op       = ALU_PASSB;
        halted       = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_instr = 1'b1;
                // no IR load while reset holds the FSM in FETCH
                if (mem_ready && !reset) begin
                    ir_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                reg2loc = is_rtype(w_class);
                w_next  = (w_class == C_ILLEGAL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (w_class)
                    C_B: begin
                        pc_write  = 1'b1;
                        uncond_br = 1'b1;
                        br_taken  = 1'b1;
                        w_next    = S_FETCH;
                    end
                    C_CBZ: begin
                        pc_write = 1'b1;
                        br_taken = zero;
                        w_next   = S_FETCH;
                    end
                    C_ADDI: begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                        w_next  = S_WB;
                    end
                    C_ADDS: begin
                        alu_op     = ALU_ADD;
                        flag_write = 1'b1;
                        w_next     = S_WB;
                    end
                    C_SUBS: begin
                        alu_op     = ALU_SUB;
                        flag_write = 1'b1;
                        w_next     = S_WB;
                    end
                    C_LDUR, C_STUR: begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                        w_next  = S_MEM;
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_write = (w_class == C_STUR);
                if (mem_ready) begin
                    if (w_class == C_STUR) begin
                        pc_write = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (w_class == C_LDUR);
                w_next     = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have opcode  in  11  instruction[31:21], taken from the instruction register.
REQ-004 SHALL have zero  in  1  ALU zero flag for CBZ.
REQ-005 SHALL have mem_ready  in  1  memory completion strobe, sampled only while mem_req=1.
REQ-006 SHALL have mem_req  out  1; mem_is_instr  out  1; mem_write  out  1  memory handshake and type.
REQ-007 SHALL have ir_write, pc_write, reg_write, flag_write, reg2loc, alu_src, mem_to_reg, uncond_br, br_taken  out  1 each  datapath enables and selects.
REQ-008 SHALL have alu_op  out  3  ALU control: 000 pass B, 010 add, 011 sub.
REQ-009 SHALL have halted  out  1; retired  out  32  count of completed instructions.

Function
REQ-010 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT in a single registered state variable.
REQ-011 SHALL decode in this priority: B (opcode[10:5]=000101), CBZ ([10:3]=10110100), ADDI ([10:1]=1001000100), ADDS (10101011000), SUBS (11101011000), LDUR (11111000010), STUR (11111000000); anything else is illegal.
REQ-012 FETCH SHALL assert mem_req=1, mem_is_instr=1, mem_write=0 each cycle until mem_ready=1; in that cycle it SHALL pulse ir_write and move to DECODE.
REQ-013 DECODE SHALL last exactly one cycle: illegal -> HALT; otherwise -> EXEC; reg2loc=1 for R-type, 0 for STUR/CBZ.
REQ-014 EXEC SHALL drive alu_op/alu_src: ADDI, LDUR, STUR add with alu_src=1; ADDS add and SUBS sub with alu_src=0 and flag_write=1; CBZ pass B.
REQ-015 EXEC for B SHALL pulse pc_write, uncond_br=1, br_taken=1, then FETCH.
REQ-016 EXEC for CBZ SHALL pulse pc_write with br_taken=zero, uncond_br=0, then FETCH; pc_write is asserted even when not taken (PC+4).
REQ-017 EXEC SHALL go to MEM for LDUR/STUR and to WB for ADDI/ADDS/SUBS.
REQ-018 MEM SHALL hold mem_req=1, mem_is_instr=0, mem_write=1 for STUR or 0 for LDUR until mem_ready; then STUR -> FETCH with pc_write pulse, LDUR -> WB.
REQ-019 WB SHALL pulse reg_write and pc_write in one cycle, mem_to_reg=1 only for LDUR, then FETCH.
REQ-020 Non-branch pc_write SHALL select PC+4 (uncond_br=0, br_taken=0).
REQ-021 Cycle counts with mem_ready held 1: B/CBZ 3, R-type/ADDI/STUR 4, LDUR 5.
REQ-022 retired SHALL increment by 1 in every cycle in which pc_write=1, wrapping from FFFFFFFF to 0.
REQ-023 mem_ready while mem_req=0 SHALL be ignored; mem_req and its qualifiers SHALL be stable until accepted.
REQ-024 HALT SHALL be absorbing: halted=1, every enable 0, retired frozen, until reset.
REQ-025 Every output not explicitly asserted in a state SHALL be 0; alu_op defaults to 000.

Reset
REQ-026 reset SHALL force state to FETCH and retired to 0 immediately, independent of clk, including mid-MEM or mid-FETCH.
REQ-027 During reset all outputs SHALL be 0, except mem_req and mem_is_instr, which are 1 because the state is FETCH; the first fetch begins on the first clk edge after release.

Structure
REQ-028 State enum, ALU op codes and opcode match constants SHALL live in shared package cpu_ctrl_pkg, which ALU and top-level CPU also import.
REQ-029 Opcode classification SHALL be a separate combinational sub-module opcode_decode, with an instruction-class enum as its output.
REQ-030 State and retired SHALL be the only registers; outputs are decoded from state and class.

Verification
REQ-031 ADDS, mem_ready=1 -> FETCH,DECODE,EXEC(alu_op=010, flag_write=1),WB(reg_write=1, pc_write=1); retired 0->1 after 4 cycles.
REQ-032 LDUR, mem_ready low 3 cycles in MEM -> mem_req=1, mem_write=0 held 4 cycles; WB mem_to_reg=1; 8 cycles total.
REQ-033 CBZ, zero=0 -> EXEC pc_write=1, br_taken=0; with zero=1 -> br_taken=1; both 3 cycles.
REQ-034 Opcode 00000000000 -> HALT after DECODE, halted=1; subsequent mem_ready pulses change nothing; reset -> FETCH.
REQ-035 reset asserted mid-MEM of STUR -> mem_write drops without a clk edge; retired=0; no pc_write.
REQ-036 Preload retired=FFFFFFFF via a forced sequence, retire B -> retired=00000000.
